norm255_sched: RTL

- Shares one int8 → fp32 "divide by 255" normalizer between NUM_REQ requesters.
- Each requester presents a byte over valid/ready; the block round-robin arbitrates and sequences a multi-cycle normalize/correct/pack datapath.
- It returns the IEEE-754 single result tagged with the requester id over a backpressured output port.
- It sits between pixel/colour producers and the fp pipeline.

---
 rtl/norm255_pkg.sv | 25 ++
 rtl/norm255_sched_rr_arb.sv | 32 +++
 rtl/norm255_sched.sv | 119 +++++++++++
 3 files changed

// File: rtl/norm255_pkg.sv
// Shared types, constants and the leading-zero helper for the
// divide-by-255 normalizer.
package norm255_pkg;

    typedef enum logic [1:0] {IDLE, CALC, PACK, OUT} state_t;

    localparam logic [23:0] CORR_K   = 24'h010101;
    localparam logic [7:0]  EXP_BASE = 8'd126;

    // Returns 8 for a zero byte.
    function automatic logic [3:0] lzc8(input logic [7:0] b);
        logic [3:0] n;
        logic       found;
        n     = 4'd8;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && b[3'(7 - i)]) begin
                n     = 4'(i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/norm255_sched_rr_arb.sv
// Combinational round-robin arbiter: first valid requester strictly after
// the pointer (wrapping) wins.
module rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    id_o,
    output logic               valid_o
);

    localparam int unsigned NR = NUM_REQ;

    always_comb begin
        logic [ID_W-1:0] idx;
        grant_o = '0;
        id_o    = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = ID_W'((32'(ptr_i) + k) % NR);
            if (!valid_o && req_valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                id_o         = idx;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/norm255_sched.sv
// Shares one byte -> fp32 (x/255, truncated) normalizer between NUM_REQ
// requesters with round-robin arbitration and a backpressured result port.
module norm255_sched
    import norm255_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [31:0]          out_data,
    output logic [ID_W-1:0]      out_id,
    input  logic                 out_ready,
    output logic                 busy
);

    state_t            state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [7:0]        byte_q;
    logic [ID_W-1:0]   id_q;
    logic [3:0]        lz_q;
    logic [7:0]        xn_q;
    logic              zero_q;
    logic              out_valid_q;
    logic [31:0]       out_data_q;
    logic [ID_W-1:0]   out_id_q;
    logic              busy_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_valid;
    logic [7:0]         sel_byte;
    logic [3:0]         lz_d;
    logic [7:0]         xn_d;
    logic [22:0]        frac_d;
    logic [31:0]        out_data_d;

    rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .id_o        (gnt_id),
        .valid_o     (gnt_valid)
    );

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) sel_byte = req_data[8*i +: 8];
        end
    end

    // xn * 0x010101 never exceeds 0xFFFFFF, so bit 23 is the implicit one.
    always_comb begin
        lz_d       = lzc8(byte_q);
        xn_d       = byte_q << lz_d;
        frac_d     = 23'({16'b0, xn_q} * CORR_K);
        out_data_d = zero_q ? '0 : {1'b0, EXP_BASE - {4'b0, lz_q}, frac_d};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            byte_q      <= '0;
            id_q        <= '0;
            lz_q        <= '0;
            xn_q        <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        byte_q  <= sel_byte;
                        id_q    <= gnt_id;
                        ptr_q   <= gnt_id;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    lz_q    <= lz_d;
                    xn_q    <= xn_d;
                    zero_q  <= (byte_q == 8'd0);
                    state_q <= PACK;
                end
                PACK: begin
                    out_data_q  <= out_data_d;
                    out_id_q    <= id_q;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = busy_q;

endmodule
